// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V opcode, field and fetch-state definitions
// Purpose : common definitions for the fetch unit and the control unit.
//           Holds the opcode localparams, the NOP encoding, the instruction
//           field-slice macros and the fetch FSM state encoding.
// Ports   : none (package).
// Config  : FETCH_MISALIGN_TRAP_EN adds the FAULT fetch state.
`ifndef RISCV_PKG_SV
`define RISCV_PKG_SV

// Field slices of a 32-bit instruction word; the argument must be a plain
// identifier because a parenthesised expression cannot be part-selected.
`define RV_OP(i)     i[6:0]
`define RV_FUNCT3(i) i[14:12]
`define RV_FUNCT7(i) i[31:25]

package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    ST_FAULT
`endif
  } fetch_state_t;

endpackage

`endif

// File: rtl/pc_next_gen.sv
// rtl/pc_next_gen.sv - next-PC mux, increment and target alignment
// Purpose : combinational next-PC selection for the fetch unit.
// Ports   : pc          in   current PC
//           pcsrc       in   select redirect target instead of pc+4
//           pctarget    in   redirect target
//           pc_next     out  next PC (pc+4 wraps modulo 2^ADDR_W)
//           misaligned  out  redirect to a non-word-aligned target
//                            (only with FETCH_MISALIGN_TRAP_EN)
// Config  : FETCH_MISALIGN_TRAP_EN passes the raw target through and flags
//           misalignment; otherwise the low two target bits are cleared.
module pc_next_gen #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pcsrc,
  input  logic [ADDR_W-1:0] pctarget,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic              misaligned,
`endif
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] target_eff;

`ifdef FETCH_MISALIGN_TRAP_EN
  // The faulting target is kept as-is so software can see where it jumped.
  assign target_eff = pctarget;
  assign misaligned = pcsrc && (pctarget[1:0] != 2'b00);
`else
  assign target_eff = {pctarget[ADDR_W-1:2], 2'b00};
`endif

  assign pc_next = pcsrc ? target_eff : (pc + ADDR_W'(4));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and instruction fetch front end
// Purpose : fetches 32-bit instructions over a req/gnt/rvalid port and holds
//           each one (with its decode fields) until execute accepts it.
// Ports   : clk, rst                      clock, async active-high reset
//           imem_req/imem_addr            fetch request and address (= pc)
//           imem_gnt/imem_rvalid/rdata    memory handshake and read data
//           instr_valid/instr_ready       hand-off to execute
//           instr, pc, Op, funct3, funct7 held instruction and its fields
//           PCSrc, PCTarget               redirect, sampled on accept only
//           fetch_fault                   sticky misaligned-redirect flag
// Config  : FETCH_MISALIGN_TRAP_EN enables the FAULT state; when undefined
//           fetch_fault is tied low and targets are word-aligned on load.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic [6:0]        Op,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] PCTarget,
  output logic              fetch_fault
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc_next;
  logic              accept;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
`endif

  pc_next_gen #(.ADDR_W(ADDR_W)) u_pc_next_gen (
    .pc         (pc),
    .pcsrc      (PCSrc),
    .pctarget   (PCTarget),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misaligned (misaligned),
`endif
    .pc_next    (pc_next)
  );

  assign accept = (state == ST_HOLD) && instr_ready;

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_nxt = ST_WAIT;
      end
      // rvalid seen in any other state is stale and falls through here.
      ST_WAIT: if (imem_rvalid) state_nxt = ST_HOLD;
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_nxt = misaligned ? ST_FAULT : ST_REQ;
`else
          state_nxt = ST_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_FAULT: state_nxt = ST_FAULT;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      if (accept) pc <= pc_next;
      if ((state == ST_WAIT) && imem_rvalid) instr <= imem_rdata;
    end
  end

  assign imem_addr = pc;
  assign Op        = `RV_OP(instr);
  assign funct3    = `RV_FUNCT3(instr);
  assign funct7    = `RV_FUNCT7(instr);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = (state == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        fetch_fault;

  int vec_cnt = 0;
  int err_cnt = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .Op          (Op),
    .funct3      (funct3),
    .funct7      (funct7),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!(imem_gnt && imem_rvalid)) else $error("gnt and rvalid in same cycle");

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, checks the address, answers after the
  // given gnt/rvalid delays and checks the held instruction that results.
  task automatic serve(input int gdly, input int rdly, input logic [31:0] data,
                       input logic [31:0] exp_addr, input bit stray);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", imem_req, 1);
    chk("req_addr", imem_addr, exp_addr);
    for (int i = 0; i < gdly; i++) begin
      imem_rvalid = stray && (i == 0);
      imem_rdata  = 32'hdead_beef;
      @(negedge clk);
      imem_rvalid = 1'b0;
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, exp_addr);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("wait_noreq", imem_req, 0);
      chk("wait_novalid", instr_valid, 0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("hold_valid", instr_valid, 1);
    chk("hold_instr", instr, data);
    chk("hold_pc", pc, exp_addr);
  endtask

  task automatic accept(input logic src, input logic [31:0] tgt);
    chk("acc_valid", instr_valid, 1);
    instr_ready = 1'b1;
    PCSrc       = src;
    PCTarget    = tgt;
    @(negedge clk);
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = 32'h0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);

    // 1: first fetch, zero-wait memory, instr_valid on cycle 3
    rst = 1'b0;
    @(negedge clk);
    chk("t1_req_c1", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_valid_c1", instr_valid, 0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("t1_req_c2", imem_req, 0);
    chk("t1_valid_c2", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t1_valid_c3", instr_valid, 1);
    chk("t1_op", Op, 7'h13);
    chk("t1_funct3", funct3, 3'h0);
    chk("t1_funct7", funct7, 7'h00);

    // 2: sequential fetches 4, 8, C with a stalled consumer
    accept(1'b0, 32'h0);
    serve(0, 0, 32'h4020_8033, 32'h4, 1'b0);
    chk("t2_op", Op, 7'h33);
    chk("t2_funct7", funct7, 7'h20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", instr_valid, 1);
      chk("t2_stall_instr", instr, 32'h4020_8033);
      chk("t2_stall_pc", pc, 32'h4);
      chk("t2_stall_req", imem_req, 0);
    end
    accept(1'b0, 32'h0);
    serve(0, 0, 32'h0000_2303, 32'h8, 1'b0);
    chk("t2_funct3", funct3, 3'h2);
    chk("t2_op_ld", Op, 7'h03);
    accept(1'b0, 32'h0);
    serve(0, 0, 32'h0000_0013, 32'hc, 1'b0);

    // 3: redirect ignored without accept, taken on accept
    PCSrc    = 1'b1;
    PCTarget = 32'h80;
    repeat (2) @(negedge clk);
    chk("t3_ign_pc", pc, 32'hc);
    chk("t3_ign_valid", instr_valid, 1);
    accept(1'b1, 32'h40);
    serve(0, 0, 32'h0000_006f, 32'h40, 1'b0);

    // 4: slow memory with a stray rvalid while requesting
    accept(1'b0, 32'h0);
    serve(4, 3, 32'h0011_0113, 32'h44, 1'b1);

    // wrap of pc+4 at the top of the address space
    accept(1'b1, 32'hffff_fffc);
    serve(0, 0, 32'h0000_0063, 32'hffff_fffc, 1'b0);
    accept(1'b0, 32'h0);
    serve(0, 0, 32'h0000_0023, 32'h0, 1'b0);

    // 5: reset while waiting for rvalid, stale rvalid after release
    accept(1'b0, 32'h0);
    @(negedge clk);
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 32'h4);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_pc", pc, 32'h0);
    chk("t5_rst_req", imem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hbad0_0bad;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t5_stale_instr", instr, 32'h0000_0013);
    chk("t5_stale_valid", instr_valid, 0);
    serve(0, 0, 32'h0020_0193, 32'h0, 1'b0);

    // 6: misaligned redirect
    accept(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_fault", fetch_fault, 1);
    chk("t6_fault_pc", pc, 32'h42);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_fault_req", imem_req, 0);
      chk("t6_fault_valid", instr_valid, 0);
      chk("t6_fault_sticky", fetch_fault, 1);
    end
`else
    serve(0, 0, 32'h0000_0013, 32'h40, 1'b0);
    chk("t6_nofault", fetch_fault, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
